// File: rtl/spi_dev_proto_regbus.sv
// rtl/spi_dev_proto_regbus.sv - SPI device protocol layer: command/address decode onto a byte-wide register bus
module spi_dev_proto_regbus #(
    parameter int          AW          = 16,
    parameter int          DUMMY_BYTES = 1,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [7:0]  FILL_BYTE   = 8'h00,
    parameter logic [7:0]  CMD_WR      = 8'h02,
    parameter logic [7:0]  CMD_RD      = 8'h03
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    usr_mosi_data,
    input  logic          usr_mosi_stb,
    output logic [7:0]    usr_miso_data,
    input  logic          usr_miso_ack,
    input  logic          csn_state,
    input  logic          csn_rise,
    input  logic          csn_fall,
    output logic [AW-1:0] bus_addr,
    output logic [7:0]    bus_wdata,
    output logic          bus_we,
    output logic          bus_re,
    input  logic [7:0]    bus_rdata,
    input  logic          bus_rvalid,
    output logic          err_underrun,
    output logic          pw_end
);
    localparam int         ADDR_BYTES = AW / 8;
    localparam logic [1:0] LAST_AB    = 2'(ADDR_BYTES - 1);
    localparam logic [7:0] LAST_FILL  = 8'(ADDR_BYTES + DUMMY_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_RDATA, S_DROP} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_mode_rd;
    logic [1:0]      r_acnt;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_wdata, r_rbuf, r_slot;
    logic            r_we, r_re, r_rbuf_valid, r_rd_pend, r_rd_discard, r_re_want, r_err;

    logic w_cs_reset, w_data_slot, w_in_rdata, w_is_cmd;
    logic w_consume, w_underrun, w_addr_done, w_re_req, w_re_go;

    // Either chip-select edge starts over; csn_fall alone counts as a fresh transaction.
    assign w_cs_reset  = csn_rise | csn_fall;
    assign w_data_slot = (r_slot > LAST_FILL);
    assign w_in_rdata  = (r_state == S_RDATA);
    assign w_is_cmd    = (usr_mosi_data == CMD_WR) || (usr_mosi_data == CMD_RD);
    assign w_consume   = usr_miso_ack && w_data_slot && w_in_rdata && r_rbuf_valid;
    assign w_underrun  = usr_miso_ack && w_data_slot && w_in_rdata && !r_rbuf_valid;
    assign w_addr_done = usr_mosi_stb && (r_state == S_ADDR) && (r_acnt == LAST_AB);
    // A read request waits here until the single outstanding read has returned.
    assign w_re_req    = ((w_addr_done && r_mode_rd) || w_consume || r_re_want)
                         && !w_cs_reset && !w_underrun;
    assign w_re_go     = w_re_req && !r_rd_pend && !r_re;

    assign bus_addr     = r_addr;
    assign bus_wdata    = r_wdata;
    assign bus_we       = r_we;
    assign bus_re       = r_re;
    assign err_underrun = r_err;
    assign pw_end       = csn_rise;

    always_comb begin
        usr_miso_data = FILL_BYTE;
        if (r_slot == 8'd0)
            usr_miso_data = SYNC_BYTE;
        else if (w_data_slot && w_in_rdata && r_rbuf_valid)
            usr_miso_data = r_rbuf;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_reset) begin
            w_state_nxt = S_IDLE;
        end else if (w_underrun) begin
            w_state_nxt = S_DROP;
        end else if (usr_mosi_stb) begin
            case (r_state)
                S_IDLE:  w_state_nxt = w_is_cmd ? S_ADDR : S_DROP;
                S_ADDR:  if (r_acnt == LAST_AB) w_state_nxt = r_mode_rd ? S_RDATA : S_WDATA;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mode_rd    <= 1'b0;
            r_acnt       <= 2'd0;
            r_addr       <= '0;
            r_wdata      <= 8'd0;
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_rbuf       <= 8'd0;
            r_rbuf_valid <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_discard <= 1'b0;
            r_re_want    <= 1'b0;
            r_slot       <= 8'd0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_we      <= 1'b0;
            r_re      <= w_re_go;
            r_re_want <= w_re_req && !w_re_go;

            if (usr_mosi_stb && !w_cs_reset) begin
                case (r_state)
                    S_IDLE: if (w_is_cmd) begin
                        r_mode_rd <= (usr_mosi_data == CMD_RD);
                        r_acnt    <= 2'd0;
                    end
                    S_ADDR: begin
                        r_addr <= (r_addr << 8) | AW'(usr_mosi_data);
                        r_acnt <= r_acnt + 2'd1;
                    end
                    S_WDATA: begin
                        r_we    <= 1'b1;
                        r_wdata <= usr_mosi_data;
                    end
                    default: ;
                endcase
            end
            if (r_we || w_consume)
                r_addr <= r_addr + AW'(1);

            if (r_re)
                r_rd_pend <= 1'b1;
            else if (bus_rvalid)
                r_rd_pend <= 1'b0;

            // A read still in flight at deselect belongs to the old transaction.
            if (w_cs_reset && ((r_rd_pend && !bus_rvalid) || r_re))
                r_rd_discard <= 1'b1;
            else if (bus_rvalid)
                r_rd_discard <= 1'b0;

            if (w_cs_reset || w_consume) begin
                r_rbuf_valid <= 1'b0;
            end else if (bus_rvalid && !r_rd_discard && !w_underrun) begin
                r_rbuf       <= bus_rdata;
                r_rbuf_valid <= 1'b1;
            end

            if (csn_state)
                r_slot <= 8'd0;
            else if (usr_miso_ack && (r_slot != 8'hFF))
                r_slot <= r_slot + 8'd1;

            if (csn_fall)
                r_err <= 1'b0;
            else if (w_underrun)
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_dev_proto_regbus.sv
// tb/tb_spi_dev_proto_regbus.sv - scoreboard bench with random transactions and a byte-level memory model
module tb_spi_dev_proto_regbus;
    localparam int BYTE_CYC = 10;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] FILL = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  usr_mosi_data = 8'd0;
    logic        usr_mosi_stb = 1'b0;
    logic [7:0]  usr_miso_data;
    logic        usr_miso_ack = 1'b0;
    logic        csn_state = 1'b1;
    logic        csn_rise = 1'b0;
    logic        csn_fall = 1'b0;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we, bus_re;
    logic [7:0]  bus_rdata = 8'd0;
    logic        bus_rvalid = 1'b0;
    logic        err_underrun, pw_end;

    spi_dev_proto_regbus dut (
        .clk(clk), .rst(rst),
        .usr_mosi_data(usr_mosi_data), .usr_mosi_stb(usr_mosi_stb),
        .usr_miso_data(usr_miso_data), .usr_miso_ack(usr_miso_ack),
        .csn_state(csn_state), .csn_rise(csn_rise), .csn_fall(csn_fall),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .err_underrun(err_underrun), .pw_end(pw_end)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [7:0] d; } rd_t;

    logic [7:0]  mem [0:65535];
    logic [23:0] exp_we_q[$];
    logic [15:0] exp_re_q[$];
    logic [7:0]  exp_miso_q[$];
    rd_t         pend_q[$];
    int n_checks = 0, n_fail = 0;
    int pw_cnt = 0, exp_pw = 0;
    int cyc = 0, rd_lat = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register bus memory: answers each bus_re after rd_lat cycles.
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            bus_rvalid = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus_rvalid = 1'b1;
                bus_rdata  = pend_q[0].d;
                void'(pend_q.pop_front());
            end
            if (bus_re) pend_q.push_back('{cyc + rd_lat, mem[bus_addr]});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_we) begin
                if (exp_we_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL bus_we_unexpected: got %0h/%0h expected none", bus_addr, bus_wdata);
                end else check("bus_we_addr_data", {bus_addr, bus_wdata}, exp_we_q.pop_front());
            end
            if (bus_re) begin
                if (exp_re_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL bus_re_unexpected: got %0h expected none", bus_addr);
                end else check("bus_re_addr", bus_addr, exp_re_q.pop_front());
            end
            if (usr_miso_ack) begin
                if (exp_miso_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL miso_unexpected: got %0h expected none", usr_miso_data);
                end else check("miso_byte", usr_miso_data, exp_miso_q.pop_front());
            end
            if (pw_end) pw_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cs_begin();
        csn_state = 1'b0; csn_fall = 1'b1;
        tick();
        csn_fall = 1'b0;
    endtask

    task automatic cs_end();
        csn_rise = 1'b1; csn_state = 1'b1; exp_pw++;
        tick();
        csn_rise = 1'b0;
        repeat (3) tick();
        check("pw_end_count", pw_cnt, exp_pw);
    endtask

    task automatic spi_byte(input logic [7:0] mosi, input logic [7:0] exp_m);
        exp_miso_q.push_back(exp_m);
        usr_miso_ack = 1'b1;
        tick();
        usr_miso_ack = 1'b0;
        repeat (BYTE_CYC - 1) tick();
        usr_mosi_data = mosi; usr_mosi_stb = 1'b1;
        tick();
        usr_mosi_stb = 1'b0;
    endtask

    task automatic drain_check();
        check("we_q_empty", exp_we_q.size(), 0);
        check("re_q_empty", exp_re_q.size(), 0);
        check("miso_q_empty", exp_miso_q.size(), 0);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d0, input int n, input logic use_d0);
        logic [7:0] d;
        cs_begin();
        spi_byte(8'h02, SYNC);
        spi_byte(a[15:8], FILL);
        spi_byte(a[7:0], FILL);
        for (int i = 0; i < n; i++) begin
            d = (use_d0 ? d0 + 8'(i * 17) : 8'($urandom));
            exp_we_q.push_back({a + 16'(i), d});
            spi_byte(d, FILL);
        end
        cs_end();
        repeat (4) tick();
        drain_check();
    endtask

    // n data slots are clocked; each consumed byte triggers one more prefetch.
    task automatic do_read(input logic [15:0] a, input int n, input int lat);
        rd_lat = lat;
        cs_begin();
        spi_byte(8'h03, SYNC);
        spi_byte(a[15:8], FILL);
        exp_re_q.push_back(a);
        spi_byte(a[7:0], FILL);
        spi_byte(8'($urandom), FILL);
        for (int i = 0; i < n; i++) begin
            exp_re_q.push_back(a + 16'(i + 1));
            spi_byte(8'($urandom), mem[a + 16'(i)]);
        end
        cs_end();
        repeat (10) tick();
        drain_check();
    endtask

    initial begin
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_re", bus_re, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_err_underrun", err_underrun, 0);
        check("rst_miso_sync", usr_miso_data, SYNC);

        do_write(16'h1234, 8'hAA, 3, 1'b1);
        // AA, BB, CC via the +17 step
        do_read(16'h0010, 3, 2);
        check("read_no_underrun", err_underrun, 0);
        do_write(16'hFFFF, 8'h00, 2, 1'b0);

        // Slow read: first data slot underruns, pending read is never consumed.
        rd_lat = 30;
        a = 16'($urandom);
        cs_begin();
        spi_byte(8'h03, SYNC);
        spi_byte(a[15:8], FILL);
        exp_re_q.push_back(a);
        spi_byte(a[7:0], FILL);
        spi_byte(8'h00, FILL);
        spi_byte(8'h00, FILL);
        spi_byte(8'h00, FILL);
        check("underrun_set", err_underrun, 1);
        cs_end();
        check("underrun_held_after_rise", err_underrun, 1);
        repeat (40) tick();
        drain_check();
        cs_begin();
        check("underrun_cleared_on_fall", err_underrun, 0);
        cs_end();

        // Deselect with a read outstanding, then a new read must not see stale data.
        rd_lat = 30;
        a = 16'($urandom_range(16'h0100, 16'hFF00));
        cs_begin();
        spi_byte(8'h03, SYNC);
        spi_byte(a[15:8], FILL);
        exp_re_q.push_back(a);
        spi_byte(a[7:0], FILL);
        cs_end();
        do_read(16'h0040, 2, 2);

        cs_begin();
        spi_byte(8'h9F, SYNC);
        spi_byte(8'h12, FILL);
        spi_byte(8'h34, FILL);
        cs_end();
        drain_check();

        // Reset lands together with the second data byte of a write.
        a = 16'($urandom);
        cs_begin();
        spi_byte(8'h02, SYNC);
        spi_byte(a[15:8], FILL);
        spi_byte(a[7:0], FILL);
        exp_we_q.push_back({a, 8'h5A});
        spi_byte(8'h5A, FILL);
        exp_miso_q.push_back(FILL);
        usr_miso_ack = 1'b1;
        tick();
        usr_miso_ack = 1'b0;
        repeat (BYTE_CYC - 1) tick();
        usr_mosi_data = 8'hC3; usr_mosi_stb = 1'b1; rst = 1'b1;
        tick();
        usr_mosi_stb = 1'b0; rst = 1'b0;
        repeat (3) tick();
        check("rst_mid_write_addr", bus_addr, 0);
        cs_end();
        drain_check();
        do_write(16'($urandom), 8'h00, 2, 1'b0);

        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 2))
                0: do_write(16'($urandom), 8'h00, int'($urandom_range(1, 6)), 1'b0);
                1: do_read(16'($urandom), int'($urandom_range(1, 5)), int'($urandom_range(1, 4)));
                default: begin
                    cs_begin();
                    spi_byte(8'($urandom_range(8'h04, 8'hFF)), SYNC);
                    spi_byte(8'($urandom), FILL);
                    cs_end();
                    drain_check();
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
